// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampled UART receive deframer feeding RBR and line status bits.
// Define UART_RX_PARITY_EN to compile in the parity bit and checker.
module uart_rx_deserializer (
    input  logic       BCLK,
    input  logic       RST,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic [1:0] lcr_wls,
    input  logic       lcr_pen,
    input  logic       lcr_eps,
    input  logic       rbr_read,
    output logic [7:0] rbr,
    output logic       data_ready,
    output logic       overrun_error,
    output logic       parity_error,
    output logic       framing_error,
    output logic       break_interrupt,
    output logic       rx_busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic       rx_s1, rx_s2, armed;
    logic [2:0] state, bcnt;
    logic [3:0] scnt;
    logic [7:0] shreg, rx_data;
    logic       last_bit, par_on, perr, brk, load;

    // bits enter at the top, so a short word ends up left-aligned and is shifted down
    assign rx_data  = shreg >> (2'd3 - lcr_wls);
    assign last_bit = bcnt == 3'd4 + {1'b0, lcr_wls};
    assign load     = state == STOP && baud_tick && scnt == 4'd15;
    assign rx_busy  = state != IDLE;

`ifdef UART_RX_PARITY_EN
    logic pbit;
    assign par_on = lcr_pen;
    assign perr   = lcr_pen && ((^rx_data ^ pbit) != ~lcr_eps);
    assign brk    = rx_data == 8'd0 && !rx_s2 && !(lcr_pen && pbit);
`else
    logic unused_cfg;
    assign unused_cfg = lcr_pen ^ lcr_eps;
    assign par_on = 1'b0;
    assign perr   = 1'b0;
    assign brk    = rx_data == 8'd0 && !rx_s2;
`endif

    always_ff @(posedge BCLK) begin
        if (RST) begin
            rx_s1           <= 1'b1;
            rx_s2           <= 1'b1;
            state           <= IDLE;
            scnt            <= 4'd0;
            bcnt            <= 3'd0;
            armed           <= 1'b0;
            shreg           <= 8'd0;
            rbr             <= 8'd0;
            data_ready      <= 1'b0;
            overrun_error   <= 1'b0;
            parity_error    <= 1'b0;
            framing_error   <= 1'b0;
            break_interrupt <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit            <= 1'b0;
`endif
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            if (state == IDLE) begin
                if (rx_s2)
                    armed <= 1'b1;
                else if (armed) begin
                    state <= START;
                    scnt  <= 4'd0;
                    armed <= 1'b0;
                end
            end else if (baud_tick) begin
                scnt <= scnt + 4'd1;
                case (state)
                    START: if (scnt == 4'd7) begin
                        scnt  <= 4'd0;
                        bcnt  <= 3'd0;
                        state <= rx_s2 ? IDLE : DATA;
                    end
                    DATA: if (scnt == 4'd15) begin
                        shreg <= {rx_s2, shreg[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        if (last_bit)
                            state <= par_on ? PARITY : STOP;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: if (scnt == 4'd15) begin
                        pbit  <= rx_s2;
                        state <= STOP;
                    end
`endif
                    STOP: if (scnt == 4'd15)
                        state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            // a load beats a coincident host read, so the fresh character stays visible
            if (load) begin
                if (!data_ready || rbr_read) begin
                    rbr             <= rx_data;
                    data_ready      <= 1'b1;
                    parity_error    <= perr;
                    framing_error   <= !rx_s2;
                    break_interrupt <= brk;
                end else
                    overrun_error <= 1'b1;
            end else if (rbr_read) begin
                data_ready      <= 1'b0;
                overrun_error   <= 1'b0;
                parity_error    <= 1'b0;
                framing_error   <= 1'b0;
                break_interrupt <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: randomized and directed frames checked every cycle against a
// tick-counting receiver model, plus literal expectations for the directed cases.
module tb_uart_rx_deserializer;
    logic       BCLK = 1'b0, RST = 1'b1, baud_tick = 1'b0, rx = 1'b1;
    logic [1:0] lcr_wls = 2'b11;
    logic       lcr_pen = 1'b0, lcr_eps = 1'b0, rbr_read = 1'b0;
    logic [7:0] rbr;
    logic       data_ready, overrun_error, parity_error, framing_error, break_interrupt, rx_busy;

    uart_rx_deserializer dut (
        .BCLK(BCLK), .RST(RST), .baud_tick(baud_tick), .rx(rx),
        .lcr_wls(lcr_wls), .lcr_pen(lcr_pen), .lcr_eps(lcr_eps), .rbr_read(rbr_read),
        .rbr(rbr), .data_ready(data_ready), .overrun_error(overrun_error),
        .parity_error(parity_error), .framing_error(framing_error),
        .break_interrupt(break_interrupt), .rx_busy(rx_busy)
    );

    always #5 BCLK = ~BCLK;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        bit         glitch;
        int         need;
        logic [7:0] d;
        bit         pe, fe, bi;
    } frm_t;
    frm_t fq[$];

    int tests = 0, fails = 0;
    int tp = 4, tcnt = 0;
    bit rd_rand = 0, rd_force = 0, coin_req = 0;

    bit         m_act = 0, m_arm = 0, d1 = 1, d2 = 1;
    int         m_cnt = 0, m_need = 0;
    logic [7:0] m_rbr = 0;
    bit         m_dr = 0, m_ovr = 0, m_pe = 0, m_fe = 0, m_bi = 0;

    initial forever begin
        @(posedge BCLK);
        #2;
        tcnt++;
        baud_tick = (tcnt % tp) == 0;
        rbr_read  = rd_force || (rd_rand && $urandom_range(0, 39) == 0) ||
                    (coin_req && m_act && baud_tick && m_cnt + 1 == m_need);
    end

    // receiver model: the line is seen two edges late, a frame ends after a fixed tick count
    always @(posedge BCLK) begin : mdl
        bit   syn, ld;
        frm_t f;
        syn = d2;
        d2  = d1;
        d1  = rx;
        ld  = 0;
        if (RST) begin
            d1 = 1; d2 = 1; m_act = 0; m_arm = 0; m_rbr = 0;
            m_dr = 0; m_ovr = 0; m_pe = 0; m_fe = 0; m_bi = 0;
            fq.delete();
        end else begin
            if (!m_act) begin
                if (syn) m_arm = 1;
                else if (m_arm) begin
                    m_arm = 0; m_act = 1; m_cnt = 0;
                    if (fq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL model-start: start seen at %0t, expected none", $time);
                        m_need = 1 << 30;
                    end else
                        m_need = fq[0].glitch ? (1 << 30) : fq[0].need;
                end
            end else if (baud_tick) begin
                m_cnt++;
                if (m_cnt == 8 && syn) begin
                    m_act = 0;
                    if (fq.size() > 0 && fq[0].glitch) void'(fq.pop_front());
                    else begin
                        tests++; fails++;
                        $display("FAIL model-falsestart: false start at %0t, expected a frame", $time);
                    end
                end else if (m_cnt == m_need) begin
                    m_act = 0;
                    ld = 1;
                    f = fq.pop_front();
                    if (!m_dr || rbr_read) begin
                        m_rbr = f.d; m_dr = 1; m_pe = f.pe; m_fe = f.fe; m_bi = f.bi;
                    end else
                        m_ovr = 1;
                end
            end
            if (!ld && rbr_read) begin
                m_dr = 0; m_ovr = 0; m_pe = 0; m_fe = 0; m_bi = 0;
            end
        end
    end

    always @(negedge BCLK) begin
        tests++;
        if ({rbr, data_ready, overrun_error, parity_error, framing_error, break_interrupt, rx_busy} !==
            {m_rbr, m_dr, m_ovr, m_pe, m_fe, m_bi, m_act}) begin
            fails++;
            if (fails <= 30)
                $display("FAIL cycle @%0t: got rbr=%h dr=%b ovr=%b pe=%b fe=%b bi=%b busy=%b, expected rbr=%h dr=%b ovr=%b pe=%b fe=%b bi=%b busy=%b",
                         $time, rbr, data_ready, overrun_error, parity_error, framing_error,
                         break_interrupt, rx_busy, m_rbr, m_dr, m_ovr, m_pe, m_fe, m_bi, m_act);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input int bits);
        repeat (bits * 16 * tp) @(posedge BCLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pb, input logic stop, input int abort_bits);
        int         n;
        bit         pen;
        logic [7:0] dm;
        frm_t       f;
        n   = 5 + int'(lcr_wls);
        pen = PAR && lcr_pen;
        dm  = d & 8'((1 << n) - 1);
        f.glitch = 0;
        f.need   = 8 + 16 * (n + 1 + (pen ? 1 : 0));
        f.d      = dm;
        f.pe     = pen && ((^dm ^ pb) != !lcr_eps);
        f.fe     = !stop;
        f.bi     = dm == 8'd0 && !stop && !(pen && pb);
        fq.push_back(f);
        @(posedge BCLK); #1;
        rx = 1'b0; hold(1);
        for (int i = 0; i < n; i++) begin
            if (abort_bits != 0 && i == abort_bits) begin
                RST = 1'b1; rx = 1'b1;
                repeat (2) @(posedge BCLK);
                #1 RST = 1'b0;
                repeat (8) @(posedge BCLK);
                #1;
                return;
            end
            rx = dm[i]; hold(1);
        end
        if (pen) begin rx = pb; hold(1); end
        rx = stop; hold(1);
        rx = 1'b1;
        repeat (8) @(posedge BCLK);
        #1;
    endtask

    task automatic send_break();
        int   n;
        bit   pen;
        frm_t f;
        n   = 5 + int'(lcr_wls);
        pen = PAR && lcr_pen;
        f.glitch = 0;
        f.need   = 8 + 16 * (n + 1 + (pen ? 1 : 0));
        f.d = 8'd0; f.fe = 1; f.bi = 1; f.pe = pen && !lcr_eps;
        fq.push_back(f);
        @(posedge BCLK); #1;
        rx = 1'b0; hold(2 * (n + 2 + (pen ? 1 : 0)));
        rx = 1'b1;
        repeat (20) @(posedge BCLK);
        #1;
    endtask

    task automatic glitch();
        frm_t f;
        f.glitch = 1; f.need = 0; f.d = 0; f.pe = 0; f.fe = 0; f.bi = 0;
        fq.push_back(f);
        @(posedge BCLK); #1;
        rx = 1'b0;
        repeat (4 * tp) @(posedge BCLK);
        #1 rx = 1'b1;
        repeat (16 * tp + 10) @(posedge BCLK);
        #1;
    endtask

    task automatic pulse_read();
        @(posedge BCLK); #1 rd_force = 1;
        @(posedge BCLK); #1 rd_force = 0;
        @(posedge BCLK); #1;
    endtask

    function automatic logic [4:0] flags();
        return {data_ready, overrun_error, parity_error, framing_error, break_interrupt};
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge BCLK);
        #1 RST = 1'b0;
        @(negedge BCLK);
        chk("reset_rbr", rbr, 8'h00);
        chk("reset_flags", flags(), 5'b0);
        chk("reset_busy", rx_busy, 1'b0);
        repeat (10) @(posedge BCLK);
        #1;

        send(8'hA5, 1'b0, 1'b1, 0);
        @(negedge BCLK);
        chk("8n1_rbr", rbr, 8'hA5);
        chk("8n1_flags", flags(), 5'b10000);
        pulse_read();
        @(negedge BCLK);
        chk("read_clear", flags(), 5'b0);

        lcr_wls = 2'b10; lcr_pen = 1'b1; lcr_eps = 1'b1;
        send(8'h35, 1'b1, 1'b1, 0);
        @(negedge BCLK);
        chk("7e1_rbr", rbr, 8'h35);
        chk("7e1_pe", parity_error, PAR);
        pulse_read();
        @(negedge BCLK);
        chk("7e1_clear", flags(), 5'b0);
        lcr_wls = 2'b11; lcr_pen = 1'b0; lcr_eps = 1'b0;

        send(8'h55, 1'b0, 1'b1, 0);
        send(8'h0F, 1'b0, 1'b1, 0);
        @(negedge BCLK);
        chk("ovr_rbr", rbr, 8'h55);
        chk("ovr_flags", flags(), 5'b11000);
        pulse_read();
        send(8'h55, 1'b0, 1'b1, 0);
        coin_req = 1;
        send(8'h0F, 1'b0, 1'b1, 0);
        coin_req = 0;
        @(negedge BCLK);
        chk("coin_rbr", rbr, 8'h0F);
        chk("coin_flags", flags(), 5'b10000);
        pulse_read();

        send_break();
        @(negedge BCLK);
        chk("brk_rbr", rbr, 8'h00);
        chk("brk_flags", flags(), 5'b10011);
        pulse_read();

        glitch();
        @(negedge BCLK);
        chk("glitch_dr", data_ready, 1'b0);
        chk("glitch_busy", rx_busy, 1'b0);

        send(8'hC3, 1'b0, 1'b1, 0);
        send(8'h3C, 1'b0, 1'b1, 3);
        @(negedge BCLK);
        chk("abort_rbr", rbr, 8'h00);
        chk("abort_flags", flags(), 5'b0);
        chk("abort_busy", rx_busy, 1'b0);
        send(8'h3C, 1'b0, 1'b1, 0);
        @(negedge BCLK);
        chk("after_rst_rbr", rbr, 8'h3C);
        pulse_read();

        lcr_wls = 2'b00;
        send(8'hFF, 1'b0, 1'b1, 0);
        @(negedge BCLK);
        chk("5n1_rbr", rbr, 8'h1F);
        pulse_read();
        lcr_wls = 2'b11;

        send(8'h81, 1'b0, 1'b0, 0);
        @(negedge BCLK);
        chk("fe_rbr", rbr, 8'h81);
        chk("fe_flags", flags(), 5'b10010);
        pulse_read();

        tp = 1;
        send(8'h96, 1'b0, 1'b1, 0);
        @(negedge BCLK);
        chk("cont_tick_rbr", rbr, 8'h96);
        pulse_read();

        rd_rand = 1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d, mask;
            logic       pb;
            case ($urandom_range(0, 2))
                0: tp = 1;
                1: tp = 2;
                default: tp = 4;
            endcase
            lcr_wls = 2'($urandom_range(0, 3));
            lcr_pen = 1'($urandom_range(0, 1));
            lcr_eps = 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            mask = 8'((1 << (5 + int'(lcr_wls))) - 1);
            pb   = ^(d & mask) ^ !lcr_eps ^ ($urandom_range(0, 3) == 0);
            send(d, pb, $urandom_range(0, 5) != 0, 0);
            repeat ($urandom_range(0, 20)) @(posedge BCLK);
            #1;
        end
        rd_rand = 0;
        repeat (20) @(posedge BCLK);
        @(negedge BCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial receive front end of the UART. Oversamples the asynchronous `rx` line at 16× baud, deframes start/data/parity/stop, and loads the received character into the receiver buffer. It produces the data-ready, overrun, parity, framing and break status bits consumed by the line status register. It sits between the FPGA pin (ESP8266 TX) and the register/interrupt logic.

## Interface
- No parameters.
- `BCLK` in 1: system clock; all state is on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `baud_tick` in 1: single-cycle enable at 16× baud rate.
- `rx` in 1: asynchronous serial input, idle high.
- `lcr_wls` in 2: word length select; 00=5, 01=6, 10=7, 11=8 data bits.
- `lcr_pen` in 1: parity enable.
- `lcr_eps` in 1: even parity select (1=even, 0=odd).
- `rbr_read` in 1: single-cycle pulse when the host reads the RBR; clears status.
- `rbr` out 8: received character, LSB first on the line, zero-extended above the word length.
- `data_ready` out 1: `rbr` holds an unread character.
- `overrun_error` out 1: a character completed while `data_ready`=1.
- `parity_error` out 1: parity mismatch on the character in `rbr`.
- `framing_error` out 1: stop bit sampled low on the character in `rbr`.
- `break_interrupt` out 1: all-zero frame including the stop bit.
- `rx_busy` out 1: FSM not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer (both stages reset to 1). All references to `rx` below mean the synchronized value.
- 4-bit sample counter `scnt` advances only on `baud_tick`.
- IDLE, entry condition: an `armed` flag is set when `rx`=1 is seen in IDLE. A start is accepted only if `armed`=1 and `rx`=0, then go to START with `scnt`=0 and `armed` cleared.
- START: on the tick where `scnt`=7 (mid-bit), `rx`=1 means a false start → IDLE; otherwise `scnt`=0 → DATA.
- DATA: sample at `scnt`=15 (16 ticks after the previous sample). Shift LSB first. After 5+`lcr_wls` bits go to PARITY if parity is enabled, else STOP.
- PARITY: sample at `scnt`=15. The error condition is XOR(data bits, parity bit) ≠ ~`lcr_eps`.
- STOP: sample at `scnt`=15, then return to IDLE. Only one stop bit is checked.
- On the STOP sample cycle (load event):
  - If `data_ready`=0, or `rbr_read`=1 in the same cycle: `rbr` ← shifted data, `data_ready`=1, and `parity_error`, `framing_error`, `break_interrupt` are written with the new character's status.
  - Otherwise: `overrun_error`=1. `rbr` and the three per-character flags are kept; the new character is discarded.
- Break condition: all data bits 0, parity bit (if any) 0, and stop bit 0. A break sets `framing_error` and `break_interrupt` and loads 0x00. `armed` stays 0 until the line returns high.
- `rbr_read` with no simultaneous load clears `data_ready`, `overrun_error`, `parity_error`, `framing_error` and `break_interrupt`. `rbr` keeps its value.
- `lcr_*` inputs are sampled live. Changing them mid-frame is unsupported, and the result is undefined for that frame only.

## Timing
- Reset values: `rbr`=0x00, all status flags 0, `rx_busy`=0, state IDLE, `scnt`=0, `armed`=0, synchronizer stages 1.
- Status outputs change the cycle after the STOP-sample `baud_tick` cycle. Latency from the mid-stop bit is 1 `BCLK`, plus 2 `BCLK` of synchronizer delay from the pin.
- `rbr_read` clears the flags on the next edge.
- A load and `rbr_read` in the same cycle: the load wins. `data_ready` stays 1 and no overrun is flagged.
- Asserting `RST` mid-frame aborts it. The FSM goes to IDLE and `armed`=0, so the line must be seen high before the next start is accepted.
- `baud_tick` held high continuously is legal; the block then runs at 16 `BCLK` per bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state and checker are compiled in.
  - `lcr_pen`/`lcr_eps` behave as above.
- `UART_RX_PARITY_EN` not defined:
  - `lcr_pen` and `lcr_eps` are ignored.
  - No parity bit is expected; DATA always goes to STOP.
  - `parity_error` is tied 0.
  - The break condition ignores parity.

## Test plan
- 8N1, `baud_tick` every 4 `BCLK`, send 0xA5 → `rbr`=0xA5 and `data_ready`=1 one cycle after the mid-stop tick; all error flags 0.
- 7E1, send 0x35 with a wrong parity bit (1) → `rbr`=0x35, `parity_error`=1; `rbr_read` → all flags 0 next cycle (macro defined).
- Send 0x55 then 0x0F without `rbr_read` → `overrun_error`=1, `rbr` stays 0x55; a `rbr_read` coincident with the second load instead gives `rbr`=0x0F and `overrun_error`=0.
- Hold `rx` low for 2 frame times → one load with `rbr`=0x00, `break_interrupt`=1, `framing_error`=1; no second character until `rx` goes high and a new start arrives.
- A 0.25-bit low glitch on idle `rx` → returns to IDLE at mid-start and `data_ready` stays 0. Separately, assert `RST` mid-DATA → all outputs at reset values, and the next clean frame 0x3C is received correctly.
- 5N1 send 0x1F → `rbr`=0x1F with bits 7:5 = 0. Framing error case: stop bit 0 on 0x81 → `framing_error`=1, `break_interrupt`=0.
